// File: rtl/mnist_pkg.sv
// Shared types and sizes for the switch-driven image capture front end.
package mnist_pkg;
    typedef enum logic [1:0] {LOAD, START, WAIT, SHOW} ctrl_state_t;

    localparam int IMG_LINES  = 8;
    localparam int IMG_LINE_W = 8;
    localparam int DIGIT_W    = 4;
endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce filter, rising-edge pulse.
// Build macro DEBOUNCE_EN enables the stable-level filter (DEBOUNCE_CYCLES).
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic btnReset,
    input  logic btn,
    output logic press
);
    logic [1:0] sync_q;
    logic       lvl;
    logic       prev_q;
    logic       press_q;

    always_ff @(posedge clk or posedge btnReset) begin
        if (btnReset) sync_q <= '0;
        else          sync_q <= {sync_q[0], btn};
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Filtered level only follows after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge btnReset) begin
        if (btnReset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_q[1] == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    always_ff @(posedge clk or posedge btnReset) begin
        if (btnReset) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= lvl;
            press_q <= lvl & ~prev_q;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/capture_classify_ctrl.sv
// Line-by-line image capture from switches, classifier start/done handshake, result hold.
// Build macro DEBOUNCE_EN enables button debouncing in btn_conditioner.
module capture_classify_ctrl
    import mnist_pkg::*;
#(
    parameter int LINES           = IMG_LINES,
    parameter int LINE_W          = IMG_LINE_W,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             btnReset,
    input  logic                             btnUpdate,
    input  logic [LINE_W-1:0]                sw,
    output logic [LINES*LINE_W-1:0]          img,
    output logic [$clog2(LINES)-1:0]         line_idx,
    output logic                             cls_start,
    input  logic                             cls_done,
    input  logic [DIGIT_W-1:0]               cls_digit,
    output logic [DIGIT_W-1:0]               digit,
    output logic                             digit_valid,
    output logic                             busy
);
    localparam int IDX_W = $clog2(LINES);

    logic press;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk      (clk),
        .btnReset (btnReset),
        .btn      (btnUpdate),
        .press    (press)
    );

    ctrl_state_t               state_q, state_d;
    logic [LINES*LINE_W-1:0]   img_q, img_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DIGIT_W-1:0]        digit_q, digit_d;
    logic                      valid_q, valid_d;

    always_ff @(posedge clk or posedge btnReset) begin
        if (btnReset) begin
            state_q <= LOAD;
            img_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        valid_d = valid_q;
        case (state_q)
            LOAD: begin
                if (press) begin
                    img_d[idx_q*LINE_W +: LINE_W] = sw;
                    if (idx_q == IDX_W'(LINES - 1)) begin
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            START: state_d = WAIT;
            // Presses here are dropped, including one coincident with done.
            WAIT: begin
                if (cls_done) begin
                    digit_d = cls_digit;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    img_d             = '0;
                    img_d[LINE_W-1:0] = sw;
                    idx_d             = IDX_W'(1);
                    valid_d           = 1'b0;
                    state_d           = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign img         = img_q;
    assign line_idx    = idx_q;
    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign cls_start   = (state_q == START);
    assign busy        = (state_q == START) || (state_q == WAIT);
endmodule

// File: tb/tb_capture_classify_ctrl.sv
// Self-checking bench for capture_classify_ctrl: vector table, hand sequences, start/done scoreboard.
module tb_capture_classify_ctrl;
    logic        clk = 1'b0;
    logic        btnReset;
    logic        btnUpdate;
    logic [7:0]  sw;
    logic [63:0] img;
    logic [2:0]  line_idx;
    logic        cls_start;
    logic        cls_done;
    logic [3:0]  cls_digit;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        busy;

`ifdef DEBOUNCE_EN
    localparam int HOLD = 24;
    localparam int PLAT = 19;
`else
    localparam int HOLD = 5;
    localparam int PLAT = 3;
`endif

    capture_classify_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .btnReset    (btnReset),
        .btnUpdate   (btnUpdate),
        .sw          (sw),
        .img         (img),
        .line_idx    (line_idx),
        .cls_start   (cls_start),
        .cls_done    (cls_done),
        .cls_digit   (cls_digit),
        .digit       (digit),
        .digit_valid (digit_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    logic valid_prev = 1'b0;
    logic [63:0] exp_img_q[$];
    logic [3:0]  exp_dig_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: image checked on each start pulse, digit on valid rise.
    always @(negedge clk) begin
        if (!btnReset) begin
            if (cls_start) begin
                n_starts++;
                if (exp_img_q.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
                else                       chk("start_img", img, exp_img_q.pop_front());
            end
            if (digit_valid && !valid_prev) begin
                if (exp_dig_q.size() == 0) chk("valid_unexpected", 64'd1, 64'd0);
                else                       chk("done_digit", {60'd0, digit}, {60'd0, exp_dig_q.pop_front()});
            end
        end
        valid_prev = digit_valid;
    end

    task automatic press_btn(input logic [7:0] v);
        @(negedge clk);
        sw = v;
        btnUpdate = 1'b1;
        repeat (HOLD) @(negedge clk);
        btnUpdate = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    // Drives the final row and checks the start pulse lands the cycle after capture.
    task automatic last_press(input logic [7:0] v, input string tag);
        bit found;
        found = 1'b0;
        @(negedge clk);
        sw = v;
        btnUpdate = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (line_idx == 3'd0) found = 1'b1;
        end
        chk({tag, "_capture_seen"}, {63'd0, found}, 64'd1);
        chk({tag, "_start_hi"}, {63'd0, cls_start}, 64'd1);
        chk({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk({tag, "_start_lo"}, {63'd0, cls_start}, 64'd0);
        chk({tag, "_busy_wait"}, {63'd0, busy}, 64'd1);
        btnUpdate = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_img"},   img, 64'd0);
        chk({tag, "_idx"},   {61'd0, line_idx}, 64'd0);
        chk({tag, "_start"}, {63'd0, cls_start}, 64'd0);
        chk({tag, "_digit"}, {60'd0, digit}, 64'd0);
        chk({tag, "_valid"}, {63'd0, digit_valid}, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  sw;
        logic [2:0]  exp_idx;
        logic [63:0] exp_img;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h01, 3'd1, 64'h0000000000000001};
        tbl[1] = '{8'h02, 3'd2, 64'h0000000000000201};
        tbl[2] = '{8'h04, 3'd3, 64'h0000000000040201};
        tbl[3] = '{8'h08, 3'd4, 64'h0000000008040201};
        tbl[4] = '{8'h10, 3'd5, 64'h0000001008040201};
        tbl[5] = '{8'h20, 3'd6, 64'h0000201008040201};
        tbl[6] = '{8'h40, 3'd7, 64'h0040201008040201};

        btnReset = 1'b1; btnUpdate = 1'b0; sw = '0; cls_done = 1'b0; cls_digit = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        btnReset = 1'b0;
        repeat (2) @(negedge clk);

        // Image 1: walking one, table-driven first seven rows
        for (int i = 0; i < 7; i++) begin
            press_btn(tbl[i].sw);
            chk($sformatf("load_img_%0d", i), img, tbl[i].exp_img);
            chk($sformatf("load_idx_%0d", i), {61'd0, line_idx}, {61'd0, tbl[i].exp_idx});
            chk($sformatf("load_busy_%0d", i), {63'd0, busy}, 64'd0);
        end
        exp_img_q.push_back(64'h8040201008040201);
        last_press(8'h80, "img1");

        // Presses in WAIT are ignored
        press_btn(8'hAA);
        chk("wait_img_hold", img, 64'h8040201008040201);
        chk("wait_idx_hold", {61'd0, line_idx}, 64'd0);
        chk("wait_busy", {63'd0, busy}, 64'd1);

        exp_dig_q.push_back(4'd7);
        cls_digit = 4'd7; cls_done = 1'b1;
        @(negedge clk);
        cls_done = 1'b0; cls_digit = 4'd0;
        chk("done_valid", {63'd0, digit_valid}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("done_digit_hold", {60'd0, digit}, 64'd7);

        // SHOW -> new image, press captures row 0
        press_btn(8'hFF);
        chk("show_img", img, 64'h00000000000000FF);
        chk("show_idx", {61'd0, line_idx}, 64'd1);
        chk("show_valid", {63'd0, digit_valid}, 64'd0);
        chk("show_digit_kept", {60'd0, digit}, 64'd7);

        for (int r = 1; r < 7; r++) press_btn(8'(r * 8'h11));
        exp_img_q.push_back(64'h77665544332211FF);
        last_press(8'h77, "img2");

        // done and press in the same WAIT cycle
        exp_dig_q.push_back(4'd3);
        @(negedge clk);
        sw = 8'h99;
        btnUpdate = 1'b1;
        repeat (PLAT) @(posedge clk);
        @(negedge clk);
        cls_digit = 4'd3; cls_done = 1'b1;
        @(negedge clk);
        cls_done = 1'b0;
        btnUpdate = 1'b0;
        chk("coinc_valid", {63'd0, digit_valid}, 64'd1);
        chk("coinc_digit", {60'd0, digit}, 64'd3);
        repeat (HOLD + 5) @(negedge clk);
        chk("coinc_img", img, 64'h77665544332211FF);
        chk("coinc_idx", {61'd0, line_idx}, 64'd0);
        chk("coinc_still_show", {63'd0, digit_valid}, 64'd1);

        // Async reset after three loaded lines
        press_btn(8'h5A);
        press_btn(8'h11);
        press_btn(8'h22);
        chk("three_idx", {61'd0, line_idx}, 64'd3);
        chk("three_img", img, 64'h000000000022115A);
        #2 btnReset = 1'b1;
        #1 check_reset_vals("rst_three");
        @(negedge clk);
        btnReset = 1'b0;
        repeat (2) @(negedge clk);

        // Async reset in WAIT
        for (int r = 0; r < 7; r++) press_btn(8'hC0 + 8'(r));
        exp_img_q.push_back(64'hC7C6C5C4C3C2C1C0);
        last_press(8'hC7, "img3");
        repeat (3) @(negedge clk);
        #2 btnReset = 1'b1;
        #1 check_reset_vals("rst_wait");
        @(negedge clk);
        btnReset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef DEBOUNCE_EN
        sw = 8'h3C;
        for (int t = 0; t < 8; t++) begin
            btnUpdate = ~btnUpdate;
            repeat (5) @(negedge clk);
        end
        btnUpdate = 1'b1;
        repeat (20) @(negedge clk);
        btnUpdate = 1'b0;
        repeat (40) @(negedge clk);
        chk("debounce_idx", {61'd0, line_idx}, 64'd1);
        chk("debounce_img", img, 64'h000000000000003C);
`endif

        chk("start_count", 64'(n_starts), 64'd3);
        chk("img_sb_empty", 64'(exp_img_q.size()), 64'd0);
        chk("dig_sb_empty", 64'(exp_dig_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
